// File: rtl/sample_pipe.sv
// sample_pipe: DEPTH-stage register pipeline for WIDTH sampled channels with
// valid/ready handshakes on both ends. The ready chain is fully combinational
// from out_ready, so empty stages are always filled and the pipe never keeps
// a bubble while it is being pushed. Output polarity is set per channel by
// INV_MASK.
//
// Optional feature: define SAMPLE_PIPE_LEVEL_EN to add the `level` output,
// a registered count of full stages.
module sample_pipe #(
  parameter int              WIDTH    = 2,
  parameter int              DEPTH    = 2,
  parameter logic [WIDTH-1:0] INV_MASK = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] out_data_n
`ifdef SAMPLE_PIPE_LEVEL_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] level
`endif
);

  logic [DEPTH-1:0]            full_q, full_d;
  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0]            adv;
  logic [DEPTH-1:0]            up_full;
  logic [DEPTH-1:0][WIDTH-1:0] up_data;
  logic                        hole_below;

  // Stage i advances when out_ready is high or any stage at or after i is
  // empty; written as a running OR so there is no chained dependency on adv.
  always_comb begin
    adv        = '0;
    hole_below = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      hole_below = hole_below | ~full_q[i];
      adv[i]     = out_ready | hole_below;
    end
  end

  // Upstream view of each stage: stage 0 sees the input port.
  always_comb begin
    up_full    = '0;
    up_data    = '0;
    up_full[0] = in_valid;
    up_data[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      up_full[i] = full_q[i-1];
      up_data[i] = data_q[i-1];
    end
  end

  // Next-state: advancing stages take the upstream full bit; data only moves
  // when a real word arrives, so idle registers never toggle.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (adv[i]) begin
        full_d[i] = up_full[i];
        if (up_full[i]) begin
          data_d[i] = up_data[i];
        end
      end
    end
  end

  // Stage registers; synchronous reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign in_ready   = adv[0];
  assign out_valid  = full_q[DEPTH-1];
  assign out_data   = data_q[DEPTH-1] ^ INV_MASK;
  assign out_data_n = ~out_data;

`ifdef SAMPLE_PIPE_LEVEL_EN
  logic                        in_xfer;
  logic                        out_xfer;
  logic [$clog2(DEPTH+1)-1:0]  level_q, level_d;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // Occupancy moves only on one-sided transfers.
  always_comb begin
    level_d = level_q;
    if (in_xfer && !out_xfer) begin
      level_d = level_q + 1'b1;
    end else if (!in_xfer && out_xfer) begin
      level_d = level_q - 1'b1;
    end
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  assign level = level_q;
`endif

endmodule

// File: tb/tb_sample_pipe.sv
// Bench for sample_pipe (WIDTH=2, DEPTH=2, INV_MASK=2'b01): a directed vector
// table, two hand-written sequences, then randomized traffic against a queue
// model of an in-order buffer holding at most DEPTH words.
module tb_sample_pipe;

  localparam int         W     = 2;
  localparam int         D     = 2;
  localparam logic [1:0] INV   = 2'b01;
  localparam int         NV    = 21;
  localparam int         NRAND = 10000;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [W-1:0] out_data_n;
`ifdef SAMPLE_PIPE_LEVEL_EN
  logic [1:0]   level;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  sample_pipe #(.WIDTH(W), .DEPTH(D), .INV_MASK(INV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_data_n (out_data_n)
`ifdef SAMPLE_PIPE_LEVEL_EN
    ,
    .level      (level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst_n;
    logic       iv;
    logic [1:0] id;
    logic       ordy;
    logic       chk;
    logic       eir;
    logic       eov;
    logic [1:0] eod;
    int         elvl;
  } vec_t;

  vec_t vecs [NV];

  task automatic setv(input int k, input logic r, input logic iv, input logic [1:0] id,
                      input logic ordy, input logic chk, input logic eir, input logic eov,
                      input logic [1:0] eod, input int elvl);
    vecs[k].rst_n = r;   vecs[k].iv  = iv;  vecs[k].id  = id;  vecs[k].ordy = ordy;
    vecs[k].chk   = chk; vecs[k].eir = eir; vecs[k].eov = eov; vecs[k].eod  = eod;
    vecs[k].elvl  = elvl;
  endtask

  // Reference model state for the random phase.
  logic [1:0] mq[$];
  int         macc[$];
  int         ecount;
  logic       m_ir, m_ov;
  int         lat;
  logic       got;
  logic [1:0] held;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    //      k  rst iv data  ordy chk ir  ov  od     lvl
    setv( 0, 0, 0, 2'b00, 0, 0, 1, 0, 2'b01, 0); // reset, state unknown
    setv( 1, 0, 0, 2'b00, 0, 1, 1, 0, 2'b01, 0); // reset held second cycle
    setv( 2, 1, 1, 2'b00, 1, 1, 1, 0, 2'b01, 0); // stream A=00
    setv( 3, 1, 1, 2'b10, 1, 1, 1, 0, 2'b01, 1); // stream B=10
    setv( 4, 1, 1, 2'b11, 1, 1, 1, 1, 2'b01, 2); // stream C=11, A out
    setv( 5, 1, 0, 2'b00, 1, 1, 1, 1, 2'b11, 2); // B out
    setv( 6, 1, 0, 2'b00, 1, 1, 1, 1, 2'b10, 1); // C out
    setv( 7, 1, 1, 2'b10, 0, 1, 1, 0, 2'b10, 0); // backpressure: D=10
    setv( 8, 1, 1, 2'b11, 0, 1, 1, 0, 2'b10, 1); // E=11
    setv( 9, 1, 1, 2'b00, 0, 1, 0, 1, 2'b11, 2); // full, F refused
    setv(10, 1, 1, 2'b00, 0, 1, 0, 1, 2'b11, 2); // output held
    setv(11, 1, 1, 2'b00, 1, 1, 1, 1, 2'b11, 2); // full, in+out same edge
    setv(12, 1, 0, 2'b00, 1, 1, 1, 1, 2'b10, 2); // E out
    setv(13, 1, 0, 2'b00, 1, 1, 1, 1, 2'b01, 1); // F out
    setv(14, 1, 0, 2'b00, 1, 1, 1, 0, 2'b01, 0); // empty
    setv(15, 1, 1, 2'b10, 0, 1, 1, 0, 2'b01, 0); // G=10
    setv(16, 1, 1, 2'b11, 0, 1, 1, 0, 2'b01, 1); // H=11
    setv(17, 0, 1, 2'b00, 1, 1, 1, 1, 2'b11, 2); // reset with 2 in flight
    setv(18, 1, 0, 2'b00, 1, 1, 1, 0, 2'b01, 0); // flushed
    setv(19, 1, 0, 2'b00, 1, 1, 1, 0, 2'b01, 0); // old words never return
    setv(20, 1, 0, 2'b00, 1, 1, 1, 0, 2'b01, 0);

    for (int k = 0; k < NV; k++) begin
      rst_n = vecs[k].rst_n; in_valid = vecs[k].iv; in_data = vecs[k].id;
      out_ready = vecs[k].ordy;
      @(negedge clk);
      if (vecs[k].chk) begin
        check($sformatf("v%0d in_ready", k),   32'(in_ready),   32'(vecs[k].eir));
        check($sformatf("v%0d out_valid", k),  32'(out_valid),  32'(vecs[k].eov));
        check($sformatf("v%0d out_data", k),   32'(out_data),   32'(vecs[k].eod));
        check($sformatf("v%0d out_data_n", k), 32'(out_data_n), 32'(2'(~vecs[k].eod)));
`ifdef SAMPLE_PIPE_LEVEL_EN
        check($sformatf("v%0d level", k),      32'(level),      32'(vecs[k].elvl));
`endif
      end
      @(posedge clk); #1;
    end

    // Single-word latency: accepted at edge N, visible after edge N+D-1.
    in_valid = 1'b1; in_data = 2'b10; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0; got = 1'b0;
    for (int c = 0; c < 6 && !got; c++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    check("latency seen", 32'(got), 32'd1);
    check("latency edges", 32'(lat), 32'(D - 1));
    check("latency data", 32'(out_data), 32'(2'b10 ^ INV));
    @(posedge clk); #1;

    // Backpressure stability: fill with out_ready low, output must not move.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 2'b01; @(posedge clk); #1;
    in_data = 2'b11; @(posedge clk); #1;
    in_data = 2'b10;
    held = 2'b01 ^ INV;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("hold%0d out_data", c), 32'(out_data), 32'(held));
      check($sformatf("hold%0d in_ready", c), 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end

    // Random traffic against the queue model.
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mq.delete(); macc.delete(); ecount = 0;
    for (int n = 0; n < NRAND; n++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = 2'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      // Room exists or a word is leaving; the oldest word is visible once it
      // has had D-1 edges to cross the stages ahead of it.
      m_ir = (mq.size() < D) || out_ready;
      m_ov = (mq.size() > 0) && ((ecount - macc[0]) >= D - 1);
      check("rand in_ready", 32'(in_ready), 32'(m_ir));
      check("rand out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov) begin
        check("rand out_data", 32'(out_data), 32'(mq[0] ^ INV));
        check("rand out_data_n", 32'(out_data_n), 32'(2'(~(mq[0] ^ INV))));
      end else begin
        check("rand out_data_n inv", 32'(out_data_n ^ out_data), 32'(2'b11));
      end
`ifdef SAMPLE_PIPE_LEVEL_EN
      check("rand level", 32'(level), 32'(mq.size()));
`endif
      if (m_ov && out_ready) begin
        void'(mq.pop_front());
        void'(macc.pop_front());
      end
      if (m_ir && in_valid) begin
        mq.push_back(in_data);
        macc.push_back(ecount + 1);
      end
      @(posedge clk);
      ecount++;
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
